// File: rtl/lsu_dm_master.sv
// MEM-stage load/store unit: splits one CPU access into one or two word-aligned
// byte-lane data-memory beats and assembles/extends the load result.
module lsu_dm_master #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [3:0]        req_dmtype,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_en,
    output logic [3:0]        mem_wea,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, WAIT, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic        split_q;
    logic [3:0]  type_q;
    logic [1:0]  off_q;
    logic [3:0]  wea_hi_q;
    logic [31:0] wd_hi_q;
    logic [31:0] rd0_q;

    logic        in_legal;
    logic        in_split;
    logic [3:0]  in_mask;
    logic [3:0]  in_size;
    logic [7:0]  in_wea;
    logic [63:0] in_wd;
    logic [63:0] ld_cat;
    logic [31:0] ld_sh;
    logic [31:0] ld_ext;

    assign req_ready = (state == IDLE);

    always_comb begin
        in_legal = 1'b1;
        in_mask  = 4'h0;
        in_size  = 4'd0;
        case (req_dmtype)
            4'd0:       begin in_mask = 4'hF; in_size = 4'd4; end
            4'd1, 4'd2: begin in_mask = 4'h3; in_size = 4'd2; end
            4'd3, 4'd4: begin in_mask = 4'h1; in_size = 4'd1; end
            default:    in_legal = 1'b0;
        endcase
        in_split = ({2'b00, req_addr[1:0]} + in_size) > 4'd4;
        // Upper halves of the 8-lane / 64-bit shifts feed the second beat.
        in_wea   = {4'h0, in_mask} << req_addr[1:0];
        in_wd    = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    end

    always_comb begin
        ld_cat = split_q ? {mem_rdata, rd0_q} : {32'h0, mem_rdata};
        ld_sh  = ld_cat[{off_q, 3'b000} +: 32];
        case (type_q)
            4'd1:    ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
            4'd2:    ld_ext = {16'h0, ld_sh[15:0]};
            4'd3:    ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
            4'd4:    ld_ext = {24'h0, ld_sh[7:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            mem_en     <= 1'b0;
            mem_wea    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            we_q       <= 1'b0;
            split_q    <= 1'b0;
            type_q     <= '0;
            off_q      <= '0;
            wea_hi_q   <= '0;
            wd_hi_q    <= '0;
            rd0_q      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q     <= req_we;
                    type_q   <= req_dmtype;
                    off_q    <= req_addr[1:0];
                    split_q  <= in_split;
                    wea_hi_q <= in_wea[7:4];
                    wd_hi_q  <= in_wd[63:32];
                    if (!in_legal) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        state     <= BEAT0;
                        mem_en    <= 1'b1;
                        mem_addr  <= req_addr[ADDR_W-1:2];
                        mem_wea   <= req_we ? in_wea[3:0] : 4'h0;
                        mem_wdata <= in_wd[31:0];
                    end
                end
                BEAT0: begin
                    if (split_q) begin
                        state     <= BEAT1;
                        mem_addr  <= mem_addr + {{(ADDR_W-3){1'b0}}, 1'b1};
                        mem_wea   <= we_q ? wea_hi_q : 4'h0;
                        mem_wdata <= wd_hi_q;
                    end else begin
                        mem_en  <= 1'b0;
                        mem_wea <= '0;
                        if (we_q) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                BEAT1: begin
                    rd0_q   <= mem_rdata;
                    mem_en  <= 1'b0;
                    mem_wea <= '0;
                    if (we_q) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    state      <= DONE;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= ld_ext;
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dm_master.sv
// Bench for lsu_dm_master: byte-level reference memory predicts beats and
// responses, a behavioural dm answers the beats, a monitor scores both.
module tb_lsu_dm_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_dmtype;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_en;
    logic [3:0]  mem_wea;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    lsu_dm_master #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_dmtype (req_dmtype),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_en     (mem_en),
        .mem_wea    (mem_wea),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  wea;
        logic [31:0] wdata;
        bit          chk_wd;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } resp_t;

    beat_t beat_q[$];
    resp_t resp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;

    logic [31:0] dm   [logic [29:0]];
    logic [7:0]  refm [logic [31:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous dm: read data appears the cycle after the beat.
    always @(posedge clk) begin : dm_model
        logic [31:0] w;
        if (mem_en) begin
            w = dm.exists(mem_addr) ? dm[mem_addr] : 32'h0;
            mem_rdata <= w;
            for (int i = 0; i < 4; i++)
                if (mem_wea[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            dm[mem_addr] = w;
        end
    end

    always @(negedge clk) begin : monitor
        beat_t b;
        resp_t r;
        if (rstn) begin
            if (mem_en) begin
                if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
                else begin
                    b = beat_q.pop_front();
                    chk("beat_addr", mem_addr, b.addr);
                    chk("beat_wea", mem_wea, b.wea);
                    if (b.chk_wd) chk("beat_wdata", mem_wdata, b.wdata);
                end
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    r = resp_q.pop_front();
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_err", resp_err, r.err);
                    chk("resp_latency", cyc - r.acc + 1, r.lat);
                end
            end
        end
    end

    task automatic do_req(input bit we, input logic [3:0] ty, input logic [31:0] addr,
                          input logic [31:0] wd_in, input bit abort);
        int          size;
        int          lane;
        int          wait_n;
        bit          legal;
        bit          split;
        logic [31:0] wd;
        logic [31:0] ba;
        logic [31:0] ld;
        logic [29:0] w0;
        logic [3:0]  wea0, wea1;
        logic [31:0] wd0, wd1;
        beat_t       b;
        resp_t       r;

        @(negedge clk);
        wait_n = 0;
        while (!req_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end

        legal = (ty <= 4'd4);
        size  = (ty == 4'd0) ? 4 : (ty <= 4'd2) ? 2 : 1;
        wd    = (size == 4) ? wd_in : (wd_in & ((32'h1 << (8 * size)) - 32'h1));
        w0    = addr[31:2];
        wea0  = 4'h0; wea1 = 4'h0; wd0 = 32'h0; wd1 = 32'h0; ld = 32'h0; split = 1'b0;
        for (int k = 0; k < size; k++) begin
            ba   = addr + k;
            lane = int'(ba[1:0]);
            if (ba[31:2] == w0) begin
                wea0[lane] = 1'b1;
                wd0[8*lane +: 8] = wd[8*k +: 8];
            end else begin
                split = 1'b1;
                wea1[lane] = 1'b1;
                wd1[8*lane +: 8] = wd[8*k +: 8];
            end
            if (legal) begin
                if (we) begin
                    if (!abort || ba[31:2] == w0) refm[ba] = wd[8*k +: 8];
                end else begin
                    ld[8*k +: 8] = refm.exists(ba) ? refm[ba] : 8'h0;
                end
            end
        end
        if (ty == 4'd1) ld = {{16{ld[15]}}, ld[15:0]};
        if (ty == 4'd3) ld = {{24{ld[7]}}, ld[7:0]};

        if (legal) begin
            b.addr = w0; b.wea = we ? wea0 : 4'h0; b.wdata = wd0; b.chk_wd = we;
            beat_q.push_back(b);
            if (split && !abort) begin
                b.addr = w0 + 30'd1; b.wea = we ? wea1 : 4'h0; b.wdata = wd1; b.chk_wd = we;
                beat_q.push_back(b);
            end
        end
        if (!abort) begin
            r.rdata = (we || !legal) ? 32'h0 : ld;
            r.err   = !legal;
            r.acc   = cyc + 1;
            r.lat   = !legal ? 1 : we ? (split ? 3 : 2) : (split ? 4 : 3);
            resp_q.push_back(r);
        end

        req_valid  = 1'b1;
        req_we     = we;
        req_dmtype = ty;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        // Keep valid asserted with junk for one busy cycle; it must not be taken.
        #1;
        req_dmtype = 4'd9;
        req_addr   = $urandom;
        req_we     = ~we;
        @(posedge clk);
        if (abort) begin
            #2 rstn = 1'b0;
            #1;
            chk("abort_mem_en", mem_en, 0);
            chk("abort_mem_wea", mem_wea, 0);
            chk("abort_req_ready", req_ready, 1);
            req_valid = 1'b0;
            repeat (2) @(negedge clk);
            rstn = 1'b1;
        end else begin
            #1 req_valid = 1'b0;
        end
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_dmtype = '0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wea", mem_wea, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        rstn = 1'b1;

        do_req(1, 4'd0, 32'h0000_0100, 32'h1122_3344, 0);
        do_req(0, 4'd0, 32'h0000_0100, 32'h0, 0);
        do_req(1, 4'd3, 32'h0000_0103, 32'h0000_00AB, 0);
        do_req(0, 4'd3, 32'h0000_0103, 32'h0, 0);
        do_req(0, 4'd4, 32'h0000_0103, 32'h0, 0);
        do_req(1, 4'd0, 32'h0000_0201, 32'hDEAD_BEEF, 0);
        do_req(0, 4'd0, 32'h0000_0201, 32'h0, 0);
        do_req(1, 4'd1, 32'h0000_0007, 32'h0000_8001, 0);
        do_req(0, 4'd1, 32'h0000_0007, 32'h0, 0);
        do_req(0, 4'd2, 32'h0000_0007, 32'h0, 0);
        do_req(1, 4'd0, 32'hFFFF_FFFE, 32'hCAFE_BABE, 0);
        do_req(0, 4'd0, 32'hFFFF_FFFE, 32'h0, 0);
        do_req(0, 4'd2, 32'hFFFF_FFFF, 32'h0, 0);
        do_req(1, 4'd7, 32'h0000_0100, 32'h5555_5555, 0);
        do_req(0, 4'd15, 32'h0000_0100, 32'h0, 0);

        for (int a = 0; a < 5; a++)
            do_req(1, 4'd0, 32'h300 + 4 * a, $urandom, 0);
        for (int i = 0; i < 24; i++)
            do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 4)),
                   32'h300 + $urandom_range(0, 15), $urandom, 0);

        do_req(1, 4'd0, 32'h0000_0400, 32'h0, 0);
        do_req(1, 4'd0, 32'h0000_0402, 32'h5566_7788, 1);
        do_req(0, 4'd0, 32'h0000_0400, 32'h0, 0);
        do_req(0, 4'd0, 32'h0000_0402, 32'h0, 0);

        repeat (10) @(negedge clk);
        chk("beats_left", beat_q.size(), 0);
        chk("resps_left", resp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
